pat_gen_seq: RTL
================

Name: pat_gen_seq

Overview:
Pattern-generation sequencer that feeds the pattern-check/no-PG stage. On start it walks NUM_REGS sub-registers. For each one it drives the address (si_addr), pattern word (ctl_pat_data) and pattern-gen enable (cfg_pat_gen) over a valid/ready handshake. The downstream nopg indication gates starting and aborts a run in progress.

Parameters:
ADDR_WIDTH, 32, width of the sub-register address.
DATA_WIDTH, 12, native data width of the downstream register.
NUM_REGS, 21, number of sub-registers walked per run (>=1).
SUB_REGS_DATA_WIDTH, (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH, pattern word width.
ADDR_STRIDE, 4, address increment per sub-register.

Ports:
clk_i  input  1  clock; all logic on rising edge.
rst_i  input  1  synchronous, active-high reset.
start_i  input  1  start-run request; sampled only in IDLE.
base_addr_i  input  ADDR_WIDTH  address of sub-register 0; captured at start.
seed_i  input  SUB_REGS_DATA_WIDTH  pattern seed; captured at start.
mode_i  input  2  pattern mode; captured at start.
nopg_i  input  1  downstream no-pattern-gen flag.
ready_i  input  1  downstream accepts the current beat.
valid_o  output  1  beat valid.
si_addr_o  output  ADDR_WIDTH  current sub-register address.
ctl_pat_data_o  output  SUB_REGS_DATA_WIDTH  current pattern word.
cfg_pat_gen_o  output  1  pattern generation active.
idx_o  output  clog2(NUM_REGS) (min 1)  current beat index.
busy_o  output  1  run in progress.
done_o  output  1  one-cycle pulse: run completed.
abort_o  output  1  one-cycle pulse: run aborted by nopg_i.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (clk_i, rst_i).
- Reset values: all outputs 0, state IDLE, idx 0, captured registers 0. Reset mid-run drops valid_o on the next edge; no done_o or abort_o pulse is issued.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start_i=1 and nopg_i=0: capture base_addr_i, seed_i, mode_i; idx<=0; go to RUN.
  - start_i=1 and nopg_i=1: ignored, stay in IDLE.
  - Latency: valid_o is high in the cycle after start_i is accepted.
- RUN:
  - valid_o=1, busy_o=1, cfg_pat_gen_o=1.
  - A transfer occurs when valid_o and ready_i are both 1. On each transfer idx increments.
  - When valid_o=1 and ready_i=0, si_addr_o, ctl_pat_data_o and idx_o hold stable.
  - Transfer with idx=NUM_REGS-1: go to DONE.
  - nopg_i=1 in RUN: go to IDLE. abort_o=1 for one cycle after that edge; valid_o, busy_o and cfg_pat_gen_o are 0 from the next cycle.
  - A transfer on the same edge as nopg_i=1 is complete (consumed), not repeated.
  - Last-beat transfer coincident with nopg_i=1: DONE wins, no abort.
  - start_i is ignored in RUN.
- DONE: lasts one cycle with done_o=1 and valid_o=0, then go to IDLE. start_i is ignored in DONE.
- Address: si_addr_o = base + idx*ADDR_STRIDE, computed modulo 2^ADDR_WIDTH (wraps silently).
- Pattern word, by mode:
  - 00 increment: seed + idx, modulo 2^SUB_REGS_DATA_WIDTH.
  - 01 walking-one: 1 << (idx mod SUB_REGS_DATA_WIDTH).
  - 10 alternate: seed for even idx, ~seed for odd idx.
  - 11 constant: seed.
- Outputs are registered. si_addr_o and ctl_pat_data_o are 0 whenever valid_o=0.

Test Plan:
1. Increment run, no backpressure. base=0x1000, seed=0x100, mode=00, ready_i=1 -> 21 beats on consecutive cycles:
   - addr 0x1000, 0x1004, ..., 0x1050.
   - data 0x100..0x114.
   - done_o pulses the cycle after beat 20; busy_o stays high exactly 21 cycles.
2. Backpressure. ready_i low on beats 3-5 for 4 cycles each -> beats 3-5 hold addr and data stable while stalled. No beat is lost or duplicated; still 21 transfers total.
3. Abort.
   - nopg_i=1 during beat 7 with ready_i=1 -> beat 7 counts, abort_o pulses once, valid_o=0 next cycle, no done_o.
   - Then start_i with nopg_i=1 -> stays in IDLE.
4. Address wrap and walking-one. base=0xFFFF_FFF8, mode=01:
   - addr sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000, ...
   - data idx0=0x1, idx5=0x20, idx20=0x10_0000.
5. Alternate mode and last-beat collision. mode=10, seed=0xA5A:
   - data alternates 0x0000_0A5A / 0xFFFF_F5A5.
   - nopg_i=1 on the final transfer -> done_o=1, abort_o=0.
6. Reset mid-run. rst_i=1 at beat 10 -> next cycle all outputs 0, no done_o or abort_o pulse. A new start then runs from idx 0.

Source files
------------

// File: rtl/pat_gen_seq.sv
// Pattern-generation sequencer: walks NUM_REGS sub-registers and emits addr/pattern beats to the nopg stage.
// Latency: first beat valid the cycle after start is accepted; one beat per cycle; done pulse one cycle after last beat.
// Backpressure: valid/ready; addr, data and idx hold while ready_i is low; nopg_i aborts a run in progress.
module pat_gen_seq #(
    parameter int ADDR_WIDTH          = 32,
    parameter int DATA_WIDTH          = 12,
    parameter int NUM_REGS            = 21,
    parameter int SUB_REGS_DATA_WIDTH = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH,
    parameter int ADDR_STRIDE         = 4
) (
    input  logic                                             clk_i,
    input  logic                                             rst_i,
    input  logic                                             start_i,
    input  logic [ADDR_WIDTH-1:0]                            base_addr_i,
    input  logic [SUB_REGS_DATA_WIDTH-1:0]                   seed_i,
    input  logic [1:0]                                       mode_i,
    input  logic                                             nopg_i,
    input  logic                                             ready_i,
    output logic                                             valid_o,
    output logic [ADDR_WIDTH-1:0]                            si_addr_o,
    output logic [SUB_REGS_DATA_WIDTH-1:0]                   ctl_pat_data_o,
    output logic                                             cfg_pat_gen_o,
    output logic [((NUM_REGS > 1) ? $clog2(NUM_REGS) : 1)-1:0] idx_o,
    output logic                                             busy_o,
    output logic                                             done_o,
    output logic                                             abort_o
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int SW    = SUB_REGS_DATA_WIDTH;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [1:0] MODE_INC  = 2'b00;
    localparam logic [1:0] MODE_WALK = 2'b01;
    localparam logic [1:0] MODE_ALT  = 2'b10;

    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_REGS - 1);
    localparam logic [ADDR_WIDTH-1:0] STRIDE   = ADDR_WIDTH'(ADDR_STRIDE);
    localparam logic [SW-1:0]         PAT_ONE  = SW'(1);

    // FSM and captured run parameters
    logic [1:0]            r_state;
    logic [IDX_W-1:0]      r_idx;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [SW-1:0]         r_seed;
    logic [1:0]            r_mode;

    // Registered outputs
    logic                  r_valid;
    logic                  r_busy;
    logic                  r_cfg;
    logic                  r_done;
    logic                  r_abort;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [SW-1:0]         r_data;

    // Next-state values; outputs are derived from these so they line up with the state register
    logic [1:0]            w_nxt_state;
    logic [IDX_W-1:0]      w_nxt_idx;
    logic [ADDR_WIDTH-1:0] w_nxt_base;
    logic [SW-1:0]         w_nxt_seed;
    logic [1:0]            w_nxt_mode;
    logic                  w_nxt_abort;
    logic                  w_nxt_run;
    logic [ADDR_WIDTH-1:0] w_offset;
    logic [ADDR_WIDTH-1:0] w_nxt_addr;
    logic [31:0]           w_shamt;
    logic [SW-1:0]         w_pattern;
    logic [SW-1:0]         w_nxt_data;

    // Next-state logic: a last-beat transfer takes priority over a nopg abort
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_idx   = r_idx;
        w_nxt_base  = r_base;
        w_nxt_seed  = r_seed;
        w_nxt_mode  = r_mode;
        w_nxt_abort = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_i && !nopg_i) begin
                    w_nxt_state = ST_RUN;
                    w_nxt_idx   = '0;
                    w_nxt_base  = base_addr_i;
                    w_nxt_seed  = seed_i;
                    w_nxt_mode  = mode_i;
                end
            end
            ST_RUN: begin
                if (ready_i && (r_idx == LAST_IDX)) begin
                    w_nxt_state = ST_DONE;
                    w_nxt_idx   = '0;
                end else if (nopg_i) begin
                    w_nxt_state = ST_IDLE;
                    w_nxt_idx   = '0;
                    w_nxt_abort = 1'b1;
                end else if (ready_i) begin
                    w_nxt_idx = r_idx + 1'b1;
                end
            end
            ST_DONE: begin
                w_nxt_state = ST_IDLE;
            end
            default: begin
                w_nxt_state = ST_IDLE;
                w_nxt_idx   = '0;
            end
        endcase
    end

    // Beat address and pattern word for the next cycle; zeroed whenever no beat is offered
    always_comb begin
        w_nxt_run  = (w_nxt_state == ST_RUN);
        w_offset   = ADDR_WIDTH'(w_nxt_idx) * STRIDE;
        w_nxt_addr = w_nxt_run ? (w_nxt_base + w_offset) : '0;
        w_shamt    = 32'(w_nxt_idx) % 32'(SW);
        case (w_nxt_mode)
            MODE_INC:  w_pattern = w_nxt_seed + SW'(w_nxt_idx);
            MODE_WALK: w_pattern = PAT_ONE << w_shamt;
            MODE_ALT:  w_pattern = w_nxt_idx[0] ? ~w_nxt_seed : w_nxt_seed;
            default:   w_pattern = w_nxt_seed;
        endcase
        w_nxt_data = w_nxt_run ? w_pattern : '0;
    end

    // State, captured parameters and registered outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_base  <= '0;
            r_seed  <= '0;
            r_mode  <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_cfg   <= 1'b0;
            r_done  <= 1'b0;
            r_abort <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_idx   <= w_nxt_idx;
            r_base  <= w_nxt_base;
            r_seed  <= w_nxt_seed;
            r_mode  <= w_nxt_mode;
            r_valid <= w_nxt_run;
            r_busy  <= w_nxt_run;
            r_cfg   <= w_nxt_run;
            r_done  <= (w_nxt_state == ST_DONE);
            r_abort <= w_nxt_abort;
            r_addr  <= w_nxt_addr;
            r_data  <= w_nxt_data;
        end
    end

    assign valid_o        = r_valid;
    assign busy_o         = r_busy;
    assign cfg_pat_gen_o  = r_cfg;
    assign done_o         = r_done;
    assign abort_o        = r_abort;
    assign si_addr_o      = r_addr;
    assign ctl_pat_data_o = r_data;
    assign idx_o          = r_idx;

endmodule
